cpu_register_file: RTL and testbench
====================================

# cpu_register_file

SLURM32 general-purpose register file: the responder to the decoder's `regA_sel`/`regB_sel` read selects and the target of the writeback stage.
- Two synchronous read ports and one write port.
- Register r0 is hardwired to zero.
- After reset, a built-in clear sequencer zeroes every register before the pipeline is released.
- Sits between the instruction decoder (slot 1) and the execute stage; read data is registered so it lines up with the instruction entering slot 2.

## Interface
Parameters:
- `BITS`, 32, data width of each register.
- `REGISTER_BITS`, 8, select width; register count `NREGS = 2**REGISTER_BITS` (256).

Ports:
- `CLK`  in  1  the single clock; all state changes on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `regA_sel`  in  REGISTER_BITS  read port A select, from the decoder.
- `regB_sel`  in  REGISTER_BITS  read port B select, from the decoder.
- `stall`  in  1  pipeline stall; hold read outputs.
- `regIn_sel`  in  REGISTER_BITS  write select, from writeback.
- `regIn_data`  in  BITS  write data.
- `regIn_we`  in  1  write enable.
- `regA_data`  out  BITS  registered port A data.
- `regB_data`  out  BITS  registered port B data.
- `busy`  out  1  high while the clear sequence runs; the pipeline must stall.

## Operation
- FSM states: CLEAR, RUN.
- Reset values while `RST` is high: state = CLEAR, clear counter = 0, `regA_data` = 0, `regB_data` = 0, `busy` = 1.
- CLEAR state, each clock:
  - Writes 0 to `reg[counter]` and increments the counter.
  - When counter = NREGS-1, writes that register and moves to RUN on the same edge.
  - The counter is REGISTER_BITS wide and wraps to 0; it is not used in RUN.
  - `regIn_we` is ignored; read outputs stay 0.
- RUN state, each clock:
  - If `regIn_we` and `regIn_sel` != 0: `reg[regIn_sel]` <= `regIn_data`.
  - Writes to r0 are discarded.
  - If `stall` = 0: `regA_data` <= value of `reg[regA_sel]` and `regB_data` <= value of `reg[regB_sel]`.
  - If `stall` = 1: `regA_data` and `regB_data` hold their previous values; the write still takes effect.
- r0 always reads 0 on both ports, regardless of array contents or bypass.
- Both ports may select the same register; both return identical data.
- `RST` asserted mid-CLEAR or mid-RUN returns immediately to CLEAR with counter = 0. The full clear restarts; partially written contents are irrelevant.
- The array contains no reset logic; only the FSM, counter and output registers are async-reset. This allows block RAM inference: two read ports means duplicated RAM or a register array.

## Timing
- Read latency is 1 cycle. A select presented before edge N yields data on `regX_data` after edge N.
- Write latency is 1 cycle. A write at edge N is visible to a read sampled at edge N+1 or later.
- Same-edge read/write of the same nonzero register: the result is defined by `REGFILE_BYPASS_EN` (see Configuration).
- `busy`:
  - High from reset assertion through exactly NREGS (256) rising edges after `RST` deasserts.
  - Low from the 256th edge onward.
  - Combinational from state: busy = (state == CLEAR).
- Back-to-back writes are supported at one per cycle, with no bubbles.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - On a same-edge write and unstalled read of the same nonzero register, `regX_data` takes `regIn_data` (write-first).
  - Applies independently to both ports.
- `REGFILE_BYPASS_EN` undefined:
  - Same case returns the old array contents (read-first).
  - The pipeline hazard logic must then insert a stall for back-to-back dependencies.
- r0 forcing and stall-hold behaviour are identical in both builds.

## Test plan
- Reset clear: pulse `RST`, release. Required response:
  - `busy` = 1 for exactly 256 edges.
  - After that, reading every sel 0..255 on both ports returns 0x00000000.
- Write/read: write r5 = 0xDEADBEEF, then next cycle regA_sel = 5, regB_sel = 5 -> both outputs 0xDEADBEEF one cycle later.
- r0 protection: write r0 = 0x12345678, read regA_sel = 0 -> 0x00000000.
- Same-cycle hazard:
  - Preload r7 = 0x11111111.
  - Then in one cycle write r7 = 0x22222222 and read regA_sel = 7.
  - Bypass build -> 0x22222222; non-bypass build -> 0x11111111.
- Stall:
  - With regA_data = 0xDEADBEEF, assert `stall` and change regA_sel to 3 while writing r3 = 0xCAFEF00D -> regA_data holds 0xDEADBEEF.
  - Release stall -> regA_data = 0xCAFEF00D.
- Reset mid-clear: assert `RST` at clear count 100 and release -> `busy` high for a fresh 256 edges; writes attempted during CLEAR have no effect (r9 reads 0).

Source files
------------

// File: rtl/cpu_register_file_if.sv
// cpu_register_file_if: decoder/writeback-facing bus of the SLURM32 register file.
// Handshake: the file accepts reads and writes on every rising edge where
// busy is low (busy acts as an inverted ready; there is no valid other than
// regIn_we for writes); while busy is high all requests are dropped.
interface cpu_register_file_if #(
   parameter int BITS          = 32,
   parameter int REGISTER_BITS = 8
);
   logic [REGISTER_BITS-1:0] regA_sel;
   logic [REGISTER_BITS-1:0] regB_sel;
   logic                     stall;
   logic [REGISTER_BITS-1:0] regIn_sel;
   logic [BITS-1:0]          regIn_data;
   logic                     regIn_we;
   logic [BITS-1:0]          regA_data;
   logic [BITS-1:0]          regB_data;
   logic                     busy;
   logic                     fsm_state;   // debug view: 0 = CLEAR, 1 = RUN

   modport master (
      output regA_sel, regB_sel, stall, regIn_sel, regIn_data, regIn_we,
      input  regA_data, regB_data, busy, fsm_state
   );

   modport slave (
      input  regA_sel, regB_sel, stall, regIn_sel, regIn_data, regIn_we,
      output regA_data, regB_data, busy, fsm_state
   );
endinterface

// File: rtl/cpu_register_file.sv
// cpu_register_file: SLURM32 register file, two registered read ports, one
// write port, r0 hardwired to zero, and a post-reset clear sequencer.
// Optional feature macro: REGFILE_BYPASS_EN selects write-first behaviour on a
// same-edge write/read of the same register (default build is read-first).
module cpu_register_file #(
   parameter int BITS          = 32,
   parameter int REGISTER_BITS = 8
) (
   input logic                 CLK,
   input logic                 RST,
   cpu_register_file_if.slave  bus
);
   localparam int NREGS = 2 ** REGISTER_BITS;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t                   state_q;
   state_t                   state_d;
   logic [REGISTER_BITS-1:0] counter_q;

   // Storage has no reset so it can map onto RAM.
   logic [BITS-1:0]          regs [NREGS];

   logic                     arr_we;
   logic [REGISTER_BITS-1:0] arr_addr;
   logic [BITS-1:0]          arr_data;
   logic [BITS-1:0]          rd_a;
   logic [BITS-1:0]          rd_b;

   assign bus.busy      = (state_q == CLEAR);
   assign bus.fsm_state = state_q;

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= CLEAR;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: leave CLEAR once the last register has been zeroed.
   always_comb begin
      state_d = state_q;
      if (state_q == CLEAR && counter_q == '1) begin
         state_d = RUN;
      end
   end

   // Clear counter walks every register index once, wrapping back to 0.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         counter_q <= '0;
      end else if (state_q == CLEAR) begin
         counter_q <= counter_q + 1'b1;
      end
   end

   // Single array write port shared by the clear sequencer and writeback.
   always_comb begin
      arr_we   = 1'b0;
      arr_addr = bus.regIn_sel;
      arr_data = bus.regIn_data;
      if (state_q == CLEAR) begin
         arr_we   = 1'b1;
         arr_addr = counter_q;
         arr_data = '0;
      end else if (bus.regIn_we && bus.regIn_sel != '0) begin
         arr_we   = 1'b1;
      end
   end

   // Array write.
   always_ff @(posedge CLK) begin
      if (arr_we) begin
         regs[arr_addr] <= arr_data;
      end
   end

   // Read data selection: r0 forced to zero, optional write-first forwarding.
   always_comb begin
      rd_a = regs[bus.regA_sel];
      rd_b = regs[bus.regB_sel];
`ifdef REGFILE_BYPASS_EN
      if (bus.regIn_we && bus.regIn_sel == bus.regA_sel) begin
         rd_a = bus.regIn_data;
      end
      if (bus.regIn_we && bus.regIn_sel == bus.regB_sel) begin
         rd_b = bus.regIn_data;
      end
`endif
      if (bus.regA_sel == '0) begin
         rd_a = '0;
      end
      if (bus.regB_sel == '0) begin
         rd_b = '0;
      end
   end

   // Output registers: updated only in RUN and when the pipeline is not stalled.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         bus.regA_data <= '0;
         bus.regB_data <= '0;
      end else if (state_q == RUN && !bus.stall) begin
         bus.regA_data <= rd_a;
         bus.regB_data <= rd_b;
      end
   end
endmodule

// File: tb/tb_cpu_register_file.sv
// tb_cpu_register_file: directed bench for cpu_register_file with a
// behavioural register-file model and literal expectations.
module tb_cpu_register_file;
   localparam int NREGS = 256;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   cpu_register_file_if #(.BITS(32), .REGISTER_BITS(8)) bus ();

   cpu_register_file #(.BITS(32), .REGISTER_BITS(8)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   // Clock and reset block.
   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;
   int printed  = 0;
   logic chk_en = 1'b0;

   // Behavioural model: an array of values plus a count of clear edges left.
   logic [31:0] mem [NREGS];
   int          clear_left = NREGS;
   logic [31:0] exp_a = '0;
   logic [31:0] exp_b = '0;

   function automatic logic [31:0] model_read(input logic [7:0] sel);
      if (sel == 8'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (bus.regIn_we && bus.regIn_sel == sel) return bus.regIn_data;
`endif
      return mem[sel];
   endfunction

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         clear_left = NREGS;
         exp_a = '0;
         exp_b = '0;
         for (int i = 0; i < NREGS; i++) mem[i] = '0;
      end else if (clear_left > 0) begin
         clear_left = clear_left - 1;
      end else begin
         if (!bus.stall) begin
            exp_a = model_read(bus.regA_sel);
            exp_b = model_read(bus.regB_sel);
         end
         if (bus.regIn_we && bus.regIn_sel != 8'd0) mem[bus.regIn_sel] = bus.regIn_data;
      end
   end

   // Compare process: checks every cycle on the falling edge.
   always @(negedge CLK) begin
      if (chk_en) begin
         checks += 3;
         if (bus.busy !== (clear_left > 0)) begin
            failures++;
            if (printed < 20) $display("FAIL model_busy act=%b exp=%b t=%0t", bus.busy, (clear_left > 0), $time);
            printed++;
         end
         if (bus.regA_data !== exp_a) begin
            failures++;
            if (printed < 20) $display("FAIL model_regA act=%h exp=%h t=%0t", bus.regA_data, exp_a, $time);
            printed++;
         end
         if (bus.regB_data !== exp_b) begin
            failures++;
            if (printed < 20) $display("FAIL model_regB act=%h exp=%h t=%0t", bus.regB_data, exp_b, $time);
            printed++;
         end
      end
   end

   // Scoreboard for literal expectations.
   logic [31:0] exp_q[$];

   task automatic check_lit(input string name, input logic [31:0] act);
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", name, act, e);
      end
   endtask

   // Driver tasks.
   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic drive(input logic we, input logic [7:0] wsel, input logic [31:0] wdata,
                        input logic [7:0] asel, input logic [7:0] bsel, input logic stl);
      bus.regIn_we   = we;
      bus.regIn_sel  = wsel;
      bus.regIn_data = wdata;
      bus.regA_sel   = asel;
      bus.regB_sel   = bsel;
      bus.stall      = stl;
   endtask

   // Counts rising edges from now until busy drops, bounded.
   task automatic count_busy(output int n);
      n = 0;
      while (bus.busy && n < 400) begin
         @(posedge CLK);
         n++;
         #1;
      end
   endtask

   int n;

   initial begin
      drive(1'b0, 8'd0, 32'h0, 8'd0, 8'd0, 1'b0);
      RST = 1'b1;
      repeat (3) tick();
      chk_en = 1'b1;
      exp_q.push_back(32'h0);
      check_lit("reset_regA", bus.regA_data);
      exp_q.push_back(32'h1);
      check_lit("reset_busy", {31'h0, bus.busy});

      // Reset clear: busy for exactly 256 edges.
      RST = 1'b0;
      count_busy(n);
      exp_q.push_back(32'd256);
      check_lit("busy_edges", n);

      // Every register reads zero on both ports.
      #1;
      for (int i = 0; i < NREGS; i++) begin
         drive(1'b0, 8'd0, 32'h0, 8'(i), 8'(255 - i), 1'b0);
         tick();
      end

      // Write/read r5.
      drive(1'b1, 8'd5, 32'hDEADBEEF, 8'd0, 8'd0, 1'b0);
      tick();
      drive(1'b0, 8'd0, 32'h0, 8'd5, 8'd5, 1'b0);
      tick();
      exp_q.push_back(32'hDEADBEEF);
      check_lit("r5_portA", bus.regA_data);
      exp_q.push_back(32'hDEADBEEF);
      check_lit("r5_portB", bus.regB_data);

      // r0 protection.
      drive(1'b1, 8'd0, 32'h12345678, 8'd0, 8'd0, 1'b0);
      tick();
      drive(1'b0, 8'd0, 32'h0, 8'd0, 8'd0, 1'b0);
      tick();
      exp_q.push_back(32'h0);
      check_lit("r0_portA", bus.regA_data);

      // Same-edge hazard on r7.
      drive(1'b1, 8'd7, 32'h11111111, 8'd0, 8'd0, 1'b0);
      tick();
      drive(1'b1, 8'd7, 32'h22222222, 8'd7, 8'd0, 1'b0);
      tick();
      drive(1'b0, 8'd0, 32'h0, 8'd7, 8'd7, 1'b0);
`ifdef REGFILE_BYPASS_EN
      exp_q.push_back(32'h22222222);
`else
      exp_q.push_back(32'h11111111);
`endif
      check_lit("hazard_r7", bus.regA_data);
      tick();
      exp_q.push_back(32'h22222222);
      check_lit("r7_after", bus.regB_data);

      // Stall holds outputs while the write still lands.
      drive(1'b0, 8'd0, 32'h0, 8'd5, 8'd5, 1'b0);
      tick();
      exp_q.push_back(32'hDEADBEEF);
      check_lit("pre_stall", bus.regA_data);
      drive(1'b1, 8'd3, 32'hCAFEF00D, 8'd3, 8'd3, 1'b1);
      tick();
      drive(1'b0, 8'd0, 32'h0, 8'd3, 8'd3, 1'b1);
      exp_q.push_back(32'hDEADBEEF);
      check_lit("stall_hold_A", bus.regA_data);
      exp_q.push_back(32'hDEADBEEF);
      check_lit("stall_hold_B", bus.regB_data);
      drive(1'b0, 8'd0, 32'h0, 8'd3, 8'd3, 1'b0);
      tick();
      exp_q.push_back(32'hCAFEF00D);
      check_lit("stall_release", bus.regA_data);

      // Back-to-back writes, with reads trailing one register behind.
      for (int i = 10; i < 21; i++) begin
         drive(1'b1, 8'(i), 32'(i) * 32'h01010101, 8'(i - 1), 8'(i), 1'b0);
         tick();
      end
      drive(1'b0, 8'd0, 32'h0, 8'd20, 8'd12, 1'b0);
      tick();
      exp_q.push_back(32'h14141414);
      check_lit("b2b_r20", bus.regA_data);
      exp_q.push_back(32'h0C0C0C0C);
      check_lit("b2b_r12", bus.regB_data);

      // Reset mid-run, then again at clear count 100, writing r9 throughout.
      RST = 1'b1;
      tick();
      RST = 1'b0;
      drive(1'b1, 8'd9, 32'hA5A5A5A5, 8'd9, 8'd9, 1'b0);
      repeat (100) tick();
      RST = 1'b1;
      tick();
      exp_q.push_back(32'h1);
      check_lit("midclear_busy", {31'h0, bus.busy});
      RST = 1'b0;
      count_busy(n);
      exp_q.push_back(32'd256);
      check_lit("busy_edges_restart", n);
      #1;
      drive(1'b0, 8'd0, 32'h0, 8'd9, 8'd9, 1'b0);
      tick();
      exp_q.push_back(32'h0);
      check_lit("r9_cleared", bus.regA_data);
      tick();

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
